// File: rtl/fp_encode.sv
// fp_encode: iterative normalize / round-to-nearest-even / pack unit producing IEEE-754 half or
// single words. One alignment shift per cycle; valid/ready handshake on input and output.
module fp_encode (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        sign_in,
   input  logic [9:0]  exp_in,
   input  logic [47:0] mant_in,
   input  logic [1:0]  special_in,
   input  logic        MODE_FP,
   output logic [31:0] RESULT,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        overflow,
   output logic        underflow,
   output logic        inexact
);

   typedef enum logic [2:0] {StIdle, StAlign, StRound, StPack, StDone} state_e;

   state_e             state_q, state_d;
   logic               sign_q, sign_d;
   logic               mode_q, mode_d;
   logic [1:0]         special_q, special_d;
   // Two guard bits so alignment and rounding carries cannot wrap the exponent.
   logic signed [11:0] exp_q, exp_d;
   logic [47:0]        mant_q, mant_d;
   logic               sticky_q, sticky_d;
   logic               rnd_inexact_q, rnd_inexact_d;
   logic [31:0]        result_q, result_d;
   logic               ovf_q, ovf_d;
   logic               unf_q, unf_d;
   logic               inx_q, inx_d;
   logic               out_valid_q, out_valid_d;

   logic               guard, lsb, rnd_sticky, round_up;
   logic [47:0]        trunc_mant, ulp, rnd_mant;
   logic               hidden, ovf_hit;
   logic [7:0]         field;
   logic signed [11:0] exp_max;
   logic [31:0]        inf_word, zero_word, nan_word;

   // Format-dependent rounding terms and packing constants, derived from the held operand
   always_comb begin
      if (mode_q) begin
         guard      = mant_q[22];
         lsb        = mant_q[23];
         rnd_sticky = sticky_q | (|mant_q[21:0]);
         trunc_mant = {mant_q[47:23], 23'd0};
         ulp        = 48'h0000_0080_0000;
         exp_max    = 12'sd255;
         inf_word   = {sign_q, 31'h7F80_0000};
         zero_word  = {sign_q, 31'h0000_0000};
         nan_word   = 32'h7FC0_0000;
      end else begin
         guard      = mant_q[35];
         lsb        = mant_q[36];
         rnd_sticky = sticky_q | (|mant_q[34:0]);
         trunc_mant = {mant_q[47:36], 36'd0};
         ulp        = 48'h0010_0000_0000;
         exp_max    = 12'sd31;
         inf_word   = {16'd0, sign_q, 15'h7C00};
         zero_word  = {16'd0, sign_q, 15'h0000};
         nan_word   = 32'h0000_7E00;
      end
      round_up = guard & (rnd_sticky | lsb);
      rnd_mant = trunc_mant + (round_up ? ulp : 48'd0);
      hidden   = mant_q[46];
      // Without the hidden bit the value is denormal (or zero) and the field encodes as 0.
      field    = hidden ? exp_q[7:0] : 8'd0;
      ovf_hit  = hidden && (exp_q >= exp_max);
   end

   // Next-state and datapath updates for the normalize / round / pack sequence
   always_comb begin
      state_d       = state_q;
      sign_d        = sign_q;
      mode_d        = mode_q;
      special_d     = special_q;
      exp_d         = exp_q;
      mant_d        = mant_q;
      sticky_d      = sticky_q;
      rnd_inexact_d = rnd_inexact_q;
      result_d      = result_q;
      ovf_d         = ovf_q;
      unf_d         = unf_q;
      inx_d         = inx_q;
      out_valid_d   = out_valid_q;
      case (state_q)
         StIdle: begin
            if (in_valid) begin
               sign_d    = sign_in;
               mode_d    = MODE_FP;
               special_d = special_in;
               exp_d     = {{2{exp_in[9]}}, exp_in};
               mant_d    = mant_in;
               sticky_d  = 1'b0;
               state_d   = (special_in != 2'b00) ? StPack : StAlign;
            end
         end
         StAlign: begin
            if (mant_q == 48'd0) begin
               state_d = StRound;
            end else if (mant_q[47] || (exp_q < 12'sd1)) begin
               mant_d   = mant_q >> 1;
               exp_d    = exp_q + 12'sd1;
               sticky_d = sticky_q | mant_q[0];
            end else if (!mant_q[46] && (exp_q > 12'sd1)) begin
               mant_d = mant_q << 1;
               exp_d  = exp_q - 12'sd1;
            end else begin
               state_d = StRound;
            end
         end
         StRound: begin
            rnd_inexact_d = guard | rnd_sticky;
            // A carry out of the significand renormalizes; the bit dropped here is always 0.
            if (rnd_mant[47]) begin
               mant_d = rnd_mant >> 1;
               exp_d  = exp_q + 12'sd1;
            end else begin
               mant_d = rnd_mant;
            end
            state_d = StPack;
         end
         StPack: begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
            inx_d = 1'b0;
            case (special_q)
               2'b01:   result_d = zero_word;
               2'b10:   result_d = inf_word;
               2'b11:   result_d = nan_word;
               default: begin
                  if (ovf_hit) begin
                     result_d = inf_word;
                     ovf_d    = 1'b1;
                     inx_d    = 1'b1;
                  end else begin
                     result_d = mode_q ? {sign_q, field, mant_q[45:23]}
                                       : {16'd0, sign_q, field[4:0], mant_q[45:36]};
                     inx_d    = rnd_inexact_q;
                     unf_d    = (field == 8'd0) && rnd_inexact_q;
                  end
               end
            endcase
            out_valid_d = 1'b1;
            state_d     = StDone;
         end
         StDone: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         sign_q        <= 1'b0;
         mode_q        <= 1'b0;
         special_q     <= 2'b00;
         exp_q         <= 12'sd0;
         mant_q        <= 48'd0;
         sticky_q      <= 1'b0;
         rnd_inexact_q <= 1'b0;
         result_q      <= 32'd0;
         ovf_q         <= 1'b0;
         unf_q         <= 1'b0;
         inx_q         <= 1'b0;
         out_valid_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         sign_q        <= sign_d;
         mode_q        <= mode_d;
         special_q     <= special_d;
         exp_q         <= exp_d;
         mant_q        <= mant_d;
         sticky_q      <= sticky_d;
         rnd_inexact_q <= rnd_inexact_d;
         result_q      <= result_d;
         ovf_q         <= ovf_d;
         unf_q         <= unf_d;
         inx_q         <= inx_d;
         out_valid_q   <= out_valid_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = out_valid_q;
   assign RESULT    = result_q;
   assign overflow  = ovf_q;
   assign underflow = unf_q;
   assign inexact   = inx_q;

endmodule

// File: tb/tb_fp_encode.sv
// Testbench for fp_encode: directed vector table, handshake/reset sequences and randomized
// operands checked against an arithmetic reference model.
module tb_fp_encode;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        sign_in;
   logic [9:0]  exp_in;
   logic [47:0] mant_in;
   logic [1:0]  special_in;
   logic        MODE_FP;
   logic [31:0] RESULT;
   logic        out_valid;
   logic        out_ready;
   logic        overflow;
   logic        underflow;
   logic        inexact;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   fp_encode dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .sign_in    (sign_in),
      .exp_in     (exp_in),
      .mant_in    (mant_in),
      .special_in (special_in),
      .MODE_FP    (MODE_FP),
      .RESULT     (RESULT),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .overflow   (overflow),
      .underflow  (underflow),
      .inexact    (inexact)
   );

   typedef struct {
      logic        md;
      logic        sg;
      logic [1:0]  sp;
      logic [9:0]  ex;
      logic [47:0] m;
      logic [31:0] res;
      logic [2:0]  fl;   // {overflow, underflow, inexact}
      int          lat;
   } vec_t;

   vec_t tbl [13];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, got, want);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Accept one operand, then wait for out_valid; lat counts edges after the accept edge.
   task automatic start_op(input logic md, input logic sg, input logic [1:0] sp,
                           input logic [9:0] ex, input logic [47:0] m, output int lat);
      @(negedge clk);
      check("in_ready_before_accept", 64'(in_ready), 64'd1);
      MODE_FP    = md;
      sign_in    = sg;
      special_in = sp;
      exp_in     = ex;
      mant_in    = m;
      in_valid   = 1'b1;
      @(posedge clk);
      #1;
      in_valid   = 1'b0;
      // Scramble inputs: the DUT must work from its latched copy.
      MODE_FP    = ~md;
      sign_in    = ~sg;
      special_in = ~sp;
      exp_in     = ~ex;
      mant_in    = ~m;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 300) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (out_valid !== 1'b1) begin
         n_tests++;
         n_fail++;
         $display("FAIL timeout: out_valid low after %0d cycles, expected high", lat);
         do_reset();
      end
   endtask

   task automatic finish_op();
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   // Reference: quantize value = m/2^46 * 2^(ex-bias) onto the target format's ULP grid.
   function automatic void ref_model(input logic md, input logic sg, input logic [1:0] sp,
                                     input int ex, input logic [47:0] m,
                                     output logic [31:0] r, output logic [2:0] fl);
      int     fb, emax, p, e, te, s, field;
      longint mm, q;
      logic   g, st, ix;
      logic [31:0] inf_w, zero_w;
      fb     = md ? 23 : 10;
      emax   = md ? 255 : 31;
      inf_w  = md ? {sg, 31'h7F80_0000} : {16'h0, sg, 15'h7C00};
      zero_w = md ? {sg, 31'h0} : {16'h0, sg, 15'h0};
      fl = 3'b000;
      if (sp == 2'b11) begin
         r = md ? 32'h7FC0_0000 : 32'h0000_7E00;
         return;
      end
      if (sp == 2'b10) begin
         r = inf_w;
         return;
      end
      if (sp == 2'b01 || m == 48'd0) begin
         r = zero_w;
         return;
      end
      mm = longint'(m);
      p  = 0;
      for (int i = 0; i < 48; i++) if (m[i]) p = i;
      e  = ex + p - 46;
      te = (e < 1) ? 1 : e;
      s  = 46 - fb - (ex - te);
      if (s <= 0) begin
         q = mm << (-s);
         g = 1'b0;
         st = 1'b0;
      end else if (s >= 49) begin
         q = 0;
         g = 1'b0;
         st = 1'b1;
      end else begin
         q  = mm >> s;
         g  = mm[s-1];
         st = (mm & ((longint'(1) << (s - 1)) - 1)) != 0;
      end
      if (g && (st || q[0])) q = q + 1;
      if (q == (longint'(1) << (fb + 1))) begin
         q = q >> 1;
         te++;
      end
      ix    = g | st;
      field = (q >= (longint'(1) << fb)) ? te : 0;
      if (field >= emax) begin
         r  = inf_w;
         fl = 3'b101;
      end else begin
         r  = md ? {sg, field[7:0], q[22:0]} : {16'h0, sg, field[4:0], q[9:0]};
         fl = {1'b0, (field == 0) && ix, ix};
      end
   endfunction

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      logic [31:0] r;
      logic [2:0]  fl;
      logic        md, sg;
      logic [1:0]  sp;
      logic [9:0]  ex;
      logic [47:0] m;

      tbl[0]  = '{1'b1, 1'b0, 2'b00, 10'd127, 48'h4000_0000_0000, 32'h3F80_0000, 3'b000, 3};
      tbl[1]  = '{1'b0, 1'b0, 2'b00, 10'd15,  48'h6000_0000_0000, 32'h0000_3E00, 3'b000, 3};
      tbl[2]  = '{1'b1, 1'b0, 2'b00, 10'd127, 48'h8000_0000_0000, 32'h4000_0000, 3'b000, 4};
      tbl[3]  = '{1'b1, 1'b0, 2'b00, 10'd127, 48'h4000_0040_0000, 32'h3F80_0000, 3'b001, 3};
      tbl[4]  = '{1'b1, 1'b0, 2'b00, 10'd127, 48'h4000_00C0_0000, 32'h3F80_0002, 3'b001, 3};
      tbl[5]  = '{1'b1, 1'b0, 2'b00, 10'h3FF, 48'h4000_0000_0000, 32'h0020_0000, 3'b000, 5};
      tbl[6]  = '{1'b0, 1'b1, 2'b00, 10'd31,  48'h4000_0000_0000, 32'h0000_FC00, 3'b101, 3};
      tbl[7]  = '{1'b1, 1'b0, 2'b11, 10'd0,   48'h0,              32'h7FC0_0000, 3'b000, 1};
      tbl[8]  = '{1'b0, 1'b1, 2'b01, 10'd0,   48'h0,              32'h0000_8000, 3'b000, 1};
      tbl[9]  = '{1'b1, 1'b1, 2'b10, 10'd5,   48'h1234,           32'hFF80_0000, 3'b000, 1};
      tbl[10] = '{1'b0, 1'b0, 2'b00, 10'h3FF, 48'h4000_0000_0000, 32'h0000_0100, 3'b000, 5};
      tbl[11] = '{1'b1, 1'b0, 2'b00, 10'd254, 48'h7FFF_FFFF_FFFF, 32'h7F80_0000, 3'b101, 3};
      tbl[12] = '{1'b1, 1'b0, 2'b00, 10'd1,   48'h2000_0000_0000, 32'h0040_0000, 3'b000, 3};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      sign_in = 1'b0; exp_in = '0; mant_in = '0; special_in = 2'b00; MODE_FP = 1'b0;
      do_reset();

      // Reset state
      @(negedge clk);
      check("reset_in_ready", 64'(in_ready), 64'd1);
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_result", 64'(RESULT), 64'd0);
      check("reset_flags", 64'({overflow, underflow, inexact}), 64'd0);

      // Directed vectors
      foreach (tbl[i]) begin
         start_op(tbl[i].md, tbl[i].sg, tbl[i].sp, tbl[i].ex, tbl[i].m, lat);
         check($sformatf("vec%0d_result", i), 64'(RESULT), 64'(tbl[i].res));
         check($sformatf("vec%0d_flags", i), 64'({overflow, underflow, inexact}),
               64'(tbl[i].fl));
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'(tbl[i].lat));
         finish_op();
      end

      // Back-pressure: DONE holds while out_ready is low; new requests are ignored.
      start_op(1'b1, 1'b0, 2'b00, 10'd127, 48'h4000_0000_0000, lat);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         in_valid   = 1'b1;
         MODE_FP    = 1'b0;
         special_in = 2'b11;
         mant_in    = {$urandom, $urandom};
         @(posedge clk);
         #1;
         check("hold_result", 64'(RESULT), 64'h3F80_0000);
         check("hold_in_ready", 64'(in_ready), 64'd0);
         check("hold_out_valid", 64'(out_valid), 64'd1);
      end
      @(negedge clk);
      in_valid = 1'b0;
      finish_op();
      check("release_out_valid", 64'(out_valid), 64'd0);
      check("release_in_ready", 64'(in_ready), 64'd1);

      // Reset while aligning aborts the operation.
      @(negedge clk);
      MODE_FP = 1'b1; sign_in = 1'b0; special_in = 2'b00;
      exp_in = 10'h3FF; mant_in = 48'h4000_0000_0000; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("abort_out_valid", 64'(out_valid), 64'd0);
      check("abort_in_ready", 64'(in_ready), 64'd1);
      check("abort_result", 64'(RESULT), 64'd0);
      rst = 1'b0;
      repeat (8) @(posedge clk);
      #1 check("abort_no_output", 64'(out_valid), 64'd0);

      // Randomized operands against the reference model.
      for (int k = 0; k < 300; k++) begin
         md = 1'($urandom);
         sg = 1'($urandom);
         sp = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
         m  = {$urandom, $urandom} >> $urandom_range(0, 47);
         if (m == 48'd0) m = 48'd1;
         case ($urandom_range(0, 3))
            0: ex = 10'((md ? 127 : 15) + int'($urandom_range(0, 60)) - 30);
            1: ex = 10'(int'($urandom_range(0, 40)) - 30);
            2: ex = 10'($urandom);
            default: ex = 10'((md ? 255 : 31) + int'($urandom_range(0, 6)) - 3);
         endcase
         ref_model(md, sg, sp, int'($signed(ex)), m, r, fl);
         start_op(md, sg, sp, ex, m, lat);
         check($sformatf("rand%0d_result", k), 64'(RESULT), 64'(r));
         check($sformatf("rand%0d_flags", k), 64'({overflow, underflow, inexact}), 64'(fl));
         finish_op();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fp_encode.md
# fp_encode

Normalize, round and pack unit for the FP datapath. It takes an unpacked result (sign, biased exponent, wide significand) from the arithmetic stages and produces a packed IEEE-754 half or single word, the same format `OP_A`/`OP_B` carry into the operand decoder. Rounding is round-to-nearest-even, with denormal and overflow handling. It is iterative: one shift per cycle, under a valid/ready handshake on both sides.

## Interface
- No parameters. Formats are fixed: half = 1/5/10, bias 15; single = 1/8/23, bias 127.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: input bundle valid.
- `in_ready` out 1: high only in IDLE.
- `sign_in` in 1: result sign.
- `exp_in` in 10: signed two's-complement exponent, biased for the target format.
- `mant_in` in 48: significand. Binary point lies between bits 46 and 45; value = mant_in/2^46 · 2^(exp_in−bias).
- `special_in` in 2: 00 finite, 01 zero, 10 infinity, 11 NaN.
- `MODE_FP` in 1: 0 = half, 1 = single. Latched on accept.
- `RESULT` out 32: packed word. Half results occupy [15:0] with [31:16] = 0.
- `out_valid` out 1: RESULT and flags valid.
- `out_ready` in 1: consumer accepts.
- `overflow`, `underflow`, `inexact` out 1 each: flags, valid with `out_valid`.

## Operation
- States: IDLE, ALIGN, ROUND, PACK, DONE.
- **IDLE:** on `in_valid` (accept), latch all inputs.
  - `special_in` ≠ 00 → PACK.
  - Otherwise → ALIGN.
- **ALIGN:** one action per cycle, first match wins.
  - (a) mant == 0 → ROUND (result is zero).
  - (b) mant[47] = 1 or exp < 1 → shift mant right 1, exp += 1. Shifted-out bit ORs into a separate sticky register.
  - (c) mant[46] = 0 and exp > 1 → shift left 1, exp −= 1.
  - (d) else → ROUND.
- **ROUND:**
  - Fraction = mant[45:23] (single) or mant[45:36] (half).
  - Guard = next lower bit. Sticky = OR of remaining lower bits plus the sticky register.
  - Increment when guard & (sticky | LSB).
  - A carry into bit 47 renormalizes: shift right 1, exp += 1.
  - `inexact` = guard | sticky.
- **PACK:**
  - Exponent field = exp if hidden bit (mant[46]) = 1, else 0 (denormal or zero).
  - exp ≥ 255 (single) / 31 (half) → ±infinity (field all-ones, fraction 0); `overflow` = `inexact` = 1.
  - `underflow` = field 0 and `inexact`.
  - Specials: zero → ±0; infinity → ±inf; NaN → canonical 0x7FC00000 (single) / 0x00007E00 (half), sign ignored. Flags 0.
  - Register RESULT and flags → DONE.
- **DONE:** `out_valid` = 1, RESULT and flags held stable. On `out_ready` → IDLE.
- No new accept happens in the same cycle as the DONE→IDLE transition.

## Timing
- Reset (synchronous, next edge):
  - state = IDLE, `in_ready` = 1.
  - `out_valid` = 0, RESULT = 0, all flags = 0, sticky = 0.
  - Reset in any state aborts the operation in flight; no output is produced for it.
- Edge E0 = accept edge.
- Finite input already normalized: ALIGN exits at E1, ROUND at E2, PACK at E3; `out_valid` is high after E3 (latency 3).
- Each ALIGN shift adds one cycle. Worst case is bounded by the 10-bit exponent range.
- Special input: PACK at E1, so `out_valid` is high after E1 (latency 1).
- `in_ready` is combinational on state == IDLE. `out_valid` is registered.
- While `out_ready` = 0, DONE holds indefinitely. Input signals are ignored outside IDLE.
- Throughput: at most one result per (latency + 1) cycles.

## Test plan
- Single, `exp_in` = 127, `mant_in` = 0x4000_0000_0000 → RESULT 0x3F800000, flags 0, `out_valid` 3 cycles after accept.
- Half, `exp_in` = 15, `mant_in` = 0x6000_0000_0000 → RESULT 0x00003E00, latency 3. Single, `exp_in` = 127, `mant_in` = 0x8000_0000_0000 → 0x40000000, latency 4.
- Tie-to-even, single, `exp_in` = 127:
  - `mant_in` = (1<<46)|(1<<22) → 0x3F800000, `inexact` = 1.
  - `mant_in` = (1<<46)|(1<<23)|(1<<22) → 0x3F800002, `inexact` = 1.
- Denormal and overflow:
  - Single, `exp_in` = −1, `mant_in` = 1<<46 → 0x00200000, flags 0, latency 5.
  - Half, `exp_in` = 31, `mant_in` = 1<<46, `sign_in` = 1 → 0x0000FC00, `overflow` = `inexact` = 1.
- Specials: `special_in` = 11, single → 0x7FC00000. `special_in` = 01, half, `sign_in` = 1 → 0x00008000. Both with latency 1.
- Handshake and reset:
  - Hold `out_ready` = 0 for 10 cycles → RESULT stable, `in_ready` = 0, extra `in_valid` ignored.
  - Assert `rst` during ALIGN → after the next edge `out_valid` = 0, `in_ready` = 1, RESULT = 0.
